dmem_access_unit: RTL and testbench

Load/store unit between the execute datapath and the data-memory port of `riscv_core`. It takes the ALU result as the effective address and rs2 as store data, and runs one byte/half/word access on the `dmem_*` valid/ready interface. It returns sign- or zero-extended load data for the `RF_WRITE_LSU_OUT` write-back path. It flags misaligned accesses and memory timeouts without touching memory.

---
 rtl/riscv_defines.sv | 37 +++
 rtl/lsu_data_align.sv | 51 +++++
 rtl/dmem_access_unit.sv | 133 +++++++++++++
 tb/tb_dmem_access_unit.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_defines.sv
// rtl/riscv_defines.sv - core-wide widths and load/store unit types
package riscv_defines;

    localparam int RISCV_ADDR_WIDTH = 32;
    localparam int RISCV_WORD_WIDTH = 32;

    typedef enum logic [1:0] {
        LSU_SIZE_B = 2'b00,
        LSU_SIZE_H = 2'b01,
        LSU_SIZE_W = 2'b10
    } lsu_size_t;

    typedef enum logic [1:0] {
        LSU_ERR_NONE       = 2'b00,
        LSU_ERR_MISALIGNED = 2'b01,
        LSU_ERR_SIZE       = 2'b10,
        LSU_ERR_TIMEOUT    = 2'b11
    } lsu_err_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } lsu_state_t;

    // Illegal size takes precedence over misalignment.
    function automatic lsu_err_t lsu_check(input logic [1:0] size, input logic [1:0] off);
        if (size == 2'b11)
            return LSU_ERR_SIZE;
        if (size == LSU_SIZE_H && off[0])
            return LSU_ERR_MISALIGNED;
        if (size == LSU_SIZE_W && off != 2'b00)
            return LSU_ERR_MISALIGNED;
        return LSU_ERR_NONE;
    endfunction

endpackage

// File: rtl/lsu_data_align.sv
// rtl/lsu_data_align.sv - store lane replication/byte enables and load lane extraction
module lsu_data_align
    import riscv_defines::*;
(
    input  lsu_size_t                    st_size,
    input  logic [1:0]                   st_off,
    input  logic [RISCV_WORD_WIDTH-1:0]  st_data,
    output logic [RISCV_WORD_WIDTH-1:0]  st_wdata,
    output logic [3:0]                   st_be,
    input  lsu_size_t                    ld_size,
    input  logic [1:0]                   ld_off,
    input  logic                         ld_sign_ext,
    input  logic [RISCV_WORD_WIDTH-1:0]  ld_raw,
    output logic [RISCV_WORD_WIDTH-1:0]  ld_data
);

    logic [RISCV_WORD_WIDTH-1:0] ld_shifted;

    always_comb begin
        st_wdata = st_data;
        st_be    = 4'b0000;
        case (st_size)
            LSU_SIZE_B: begin
                st_wdata = {4{st_data[7:0]}};
                st_be    = 4'b0001 << st_off;
            end
            LSU_SIZE_H: begin
                st_wdata = {2{st_data[15:0]}};
                st_be    = 4'b0011 << st_off;
            end
            LSU_SIZE_W: begin
                st_be    = 4'b1111;
            end
            default: ;
        endcase
    end

    assign ld_shifted = ld_raw >> {ld_off, 3'b000};

    always_comb begin
        ld_data = ld_raw;
        case (ld_size)
            LSU_SIZE_B: ld_data = ld_sign_ext ? {{24{ld_shifted[7]}}, ld_shifted[7:0]}
                                              : {24'h000000, ld_shifted[7:0]};
            LSU_SIZE_H: ld_data = ld_sign_ext ? {{16{ld_shifted[15]}}, ld_shifted[15:0]}
                                              : {16'h0000, ld_shifted[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// rtl/dmem_access_unit.sv - single-access load/store unit on the dmem valid/ready port
module dmem_access_unit
    import riscv_defines::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_i,
    output logic                         req_ready_o,
    input  logic                         we_i,
    input  logic [1:0]                   size_i,
    input  logic                         sign_ext_i,
    input  logic [RISCV_ADDR_WIDTH-1:0]  addr_i,
    input  logic [RISCV_WORD_WIDTH-1:0]  wdata_i,
    output logic                         done_o,
    output logic [RISCV_WORD_WIDTH-1:0]  rdata_o,
    output logic                         err_o,
    output logic [1:0]                   err_cause_o,
    output logic                         dmem_valid_o,
    input  logic                         dmem_ready_i,
    output logic [RISCV_ADDR_WIDTH-1:0]  dmem_addr_o,
    output logic [RISCV_WORD_WIDTH-1:0]  dmem_wdata_o,
    output logic [3:0]                   dmem_we_o,
    input  logic [RISCV_WORD_WIDTH-1:0]  dmem_rdata_i
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    lsu_state_t                  state_q, state_d;
    logic                        we_q;
    lsu_size_t                   size_q;
    logic                        sign_ext_q;
    logic [1:0]                  off_q;
    logic [RISCV_ADDR_WIDTH-1:0] addr_q;
    logic [RISCV_WORD_WIDTH-1:0] wdata_q;
    logic [3:0]                  be_q;
    logic [RISCV_WORD_WIDTH-1:0] rdata_q;
    logic                        err_q;
    lsu_err_t                    cause_q;
    logic [CW-1:0]               cnt_q;

    lsu_err_t                    req_chk;
    logic                        timeout_hit;
    logic [RISCV_WORD_WIDTH-1:0] st_wdata;
    logic [3:0]                  st_be;
    logic [RISCV_WORD_WIDTH-1:0] ld_data;

    lsu_data_align u_align (
        .st_size     (lsu_size_t'(size_i)),
        .st_off      (addr_i[1:0]),
        .st_data     (wdata_i),
        .st_wdata    (st_wdata),
        .st_be       (st_be),
        .ld_size     (size_q),
        .ld_off      (off_q),
        .ld_sign_ext (sign_ext_q),
        .ld_raw      (dmem_rdata_i),
        .ld_data     (ld_data)
    );

    assign req_chk     = lsu_check(size_i, addr_i[1:0]);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_i) state_d = (req_chk == LSU_ERR_NONE) ? ACCESS : RESP;
            ACCESS:  if (dmem_ready_i || timeout_hit) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            size_q     <= LSU_SIZE_B;
            sign_ext_q <= 1'b0;
            off_q      <= 2'b00;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= 4'b0000;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            cause_q    <= LSU_ERR_NONE;
            cnt_q      <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (req_i) begin
                    we_q       <= we_i;
                    size_q     <= lsu_size_t'(size_i);
                    sign_ext_q <= sign_ext_i;
                    off_q      <= addr_i[1:0];
                    addr_q     <= {addr_i[RISCV_ADDR_WIDTH-1:2], 2'b00};
                    wdata_q    <= st_wdata;
                    be_q       <= we_i ? st_be : 4'b0000;
                    err_q      <= (req_chk != LSU_ERR_NONE);
                    cause_q    <= req_chk;
                    cnt_q      <= '0;
                end
                ACCESS: begin
                    // A ready arriving on the last timeout cycle still completes cleanly.
                    if (dmem_ready_i) begin
                        if (!we_q)
                            rdata_q <= ld_data;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        if (timeout_hit) begin
                            err_q   <= 1'b1;
                            cause_q <= LSU_ERR_TIMEOUT;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready_o  = (state_q == IDLE);
    assign done_o       = (state_q == RESP);
    assign err_o        = done_o & err_q;
    assign err_cause_o  = done_o ? cause_q : LSU_ERR_NONE;
    assign dmem_valid_o = (state_q == ACCESS);
    assign dmem_we_o    = dmem_valid_o ? be_q : 4'b0000;
    assign dmem_addr_o  = addr_q;
    assign dmem_wdata_o = wdata_q;
    assign rdata_o      = rdata_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// tb/tb_dmem_access_unit.sv - randomized scoreboard bench for dmem_access_unit
module tb_dmem_access_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_i = 1'b0;
    logic        req_ready_o;
    logic        we_i = 1'b0;
    logic [1:0]  size_i = 2'b00;
    logic        sign_ext_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic        done_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic [1:0]  err_cause_o;
    logic        dmem_valid_o;
    logic        dmem_ready_i = 1'b0;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic [3:0]  dmem_we_o;
    logic [31:0] dmem_rdata_i = '0;

    dmem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .req_ready_o(req_ready_o),
        .we_i(we_i), .size_i(size_i), .sign_ext_i(sign_ext_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .done_o(done_o), .rdata_o(rdata_o), .err_o(err_o),
        .err_cause_o(err_cause_o), .dmem_valid_o(dmem_valid_o),
        .dmem_ready_i(dmem_ready_i), .dmem_addr_o(dmem_addr_o),
        .dmem_wdata_o(dmem_wdata_o), .dmem_we_o(dmem_we_o),
        .dmem_rdata_i(dmem_rdata_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        err;
        logic [1:0]  cause;
        logic        chk_rd;
        logic [31:0] rdata;
        int          done_cyc;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
        int          wait_n;
        int          nvalid;
    } mem_t;

    exp_t exp_q[$];
    mem_t mem_q[$];

    int checks = 0;
    int passes = 0;

    logic [7:0]  ref_mem [256];
    logic [31:0] resp_mem [64];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic set_word(input logic [31:0] a, input logic [31:0] v);
        for (int i = 0; i < 4; i++) ref_mem[{a[7:2], 2'b00} + 8'(i)] = v[8*i +: 8];
        resp_mem[a[7:2]] = v;
    endtask

    // Scoreboard monitor: every done_o pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (done_o) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("done_cycle", cyc, e.done_cyc);
                chk("err", {31'd0, err_o}, {31'd0, e.err});
                chk("err_cause", {30'd0, err_cause_o}, {30'd0, e.cause});
                chk("ready_in_resp", {31'd0, req_ready_o}, 32'd0);
                if (e.chk_rd) chk("rdata", rdata_o, e.rdata);
            end
        end
    end

    // Memory responder: checks the request beat and its stability, answers after wait_n cycles.
    bit          active = 0;
    mem_t        cur;
    int          vcnt = 0;
    logic [31:0] h_addr, h_wdata;
    logic [3:0]  h_we;

    always @(negedge clk) begin
        if (dmem_valid_o) begin
            if (!active) begin
                if (mem_q.size() == 0) begin
                    chk("unexpected_valid", 32'd1, 32'd0);
                    cur = '{addr: dmem_addr_o, we: dmem_we_o, wdata: dmem_wdata_o, wait_n: 0, nvalid: 1};
                end else begin
                    cur = mem_q.pop_front();
                end
                chk("dmem_addr", dmem_addr_o, cur.addr);
                chk("dmem_we", {28'd0, dmem_we_o}, {28'd0, cur.we});
                if (cur.we != 4'b0000) chk("dmem_wdata", dmem_wdata_o, cur.wdata);
                h_addr = dmem_addr_o; h_we = dmem_we_o; h_wdata = dmem_wdata_o;
                active = 1; vcnt = 0;
            end else begin
                chk("hold_addr", dmem_addr_o, h_addr);
                chk("hold_we", {28'd0, dmem_we_o}, {28'd0, h_we});
                chk("hold_wdata", dmem_wdata_o, h_wdata);
            end
            vcnt++;
            if (vcnt - 1 == cur.wait_n) begin
                dmem_ready_i = 1'b1;
                dmem_rdata_i = resp_mem[dmem_addr_o[7:2]];
                for (int j = 0; j < 4; j++)
                    if (dmem_we_o[j]) resp_mem[dmem_addr_o[7:2]][8*j +: 8] = dmem_wdata_o[8*j +: 8];
            end else begin
                dmem_ready_i = 1'b0;
                dmem_rdata_i = $urandom;
            end
        end else begin
            if (active) begin
                chk("valid_cycles", vcnt, cur.nvalid);
                active = 0;
            end
            dmem_ready_i = 1'b0;
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!req_ready_o && n < 50) begin @(negedge clk); n++; end
        if (!req_ready_o) chk("req_ready_wait", 32'd0, 32'd1);
    endtask

    task automatic issue(input bit we, input logic [1:0] sz, input bit sx,
                         input logic [31:0] a, input logic [31:0] d, input int w);
        exp_t        e;
        mem_t        m;
        int          nb, lat, cause, n;
        logic [31:0] v, mask;
        wait_ready();
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        if (sz == 2'd3)                          cause = 2;
        else if ((a % nb) != 0)                  cause = 1;
        else                                     cause = 0;
        if (cause != 0)      lat = 1;
        else if (w >= TO) begin lat = TO + 1; cause = 3; end
        else                 lat = w + 2;
        e.err = (cause != 0);
        e.cause = 2'(cause);
        e.chk_rd = !we && cause == 0;
        v = '0;
        if (!we && cause == 0) begin
            for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[a[7:0] + 8'(i)]) << (8*i));
            if (sx && nb < 4) begin
                mask = (32'd1 << (8*nb)) - 1;
                if (v[8*nb-1]) v = v | ~mask;
            end
        end
        e.rdata = v;
        e.done_cyc = cyc + lat;
        if (cause == 0 || cause == 3) begin
            m.addr = {a[31:2], 2'b00};
            m.we = '0;
            m.wdata = '0;
            for (int j = 0; j < 4; j++) m.wdata[8*j +: 8] = d[8*(j % nb) +: 8];
            if (we) for (int i = 0; i < nb; i++) m.we[(a[1:0] + 2'(i))] = 1'b1;
            m.wait_n = w;
            m.nvalid = (w >= TO) ? TO : w + 1;
            mem_q.push_back(m);
            if (we && cause == 0)
                for (int i = 0; i < nb; i++) ref_mem[a[7:0] + 8'(i)] = d[8*i +: 8];
        end
        exp_q.push_back(e);
        req_i = 1'b1; we_i = we; size_i = sz; sign_ext_i = sx; addr_i = a; wdata_i = d;
        @(negedge clk);
        // Requests while busy must be ignored.
        req_i = 1'b1; we_i = $urandom; size_i = 2'($urandom); addr_i = $urandom; wdata_i = $urandom;
        @(negedge clk);
        req_i = 1'b0;
        n = 0;
        while ((exp_q.size() != 0 || active) && n < 60) begin @(negedge clk); n++; end
        if (exp_q.size() != 0) begin
            chk("done_wait", 32'd0, 32'd1);
            exp_q.delete();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 64; i++) set_word(32'(i * 4), $urandom);
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready_o}, 32'd1);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_err", {31'd0, err_o}, 32'd0);
        chk("rst_cause", {30'd0, err_cause_o}, 32'd0);
        chk("rst_valid", {31'd0, dmem_valid_o}, 32'd0);
        chk("rst_we", {28'd0, dmem_we_o}, 32'd0);
        chk("rst_addr", dmem_addr_o, 32'd0);
        chk("rst_wdata", dmem_wdata_o, 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(1, 2'd2, 0, 32'h100, 32'hDEADBEEF, 0);
        issue(1, 2'd0, 0, 32'h103, 32'h000000A5, 3);
        set_word(32'h100, 32'h00800000);
        issue(0, 2'd0, 1, 32'h102, 32'h0, 0);
        issue(0, 2'd0, 0, 32'h102, 32'h0, 1);
        set_word(32'h100, 32'h80015A5A);
        issue(0, 2'd1, 1, 32'h102, 32'h0, 2);
        issue(0, 2'd2, 0, 32'h101, 32'h0, 0);
        issue(0, 2'd3, 0, 32'h100, 32'h0, 0);
        issue(1, 2'd1, 0, 32'h105, 32'h1234, 0);
        issue(0, 2'd2, 0, 32'h108, 32'h0, 100);
        issue(0, 2'd2, 0, 32'h108, 32'h0, TO - 1);

        for (int t = 0; t < 80; t++)
            issue($urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom_range(0, 1),
                  32'h100 + 32'($urandom_range(0, 255)), $urandom, $urandom_range(0, 5));

        // Reset during the second ACCESS cycle drops the pending access.
        wait_ready();
        mem_q.push_back('{addr: 32'h104, we: 4'b0000, wdata: 32'h0, wait_n: 1000, nvalid: 2});
        req_i = 1'b1; we_i = 1'b0; size_i = 2'd2; sign_ext_i = 1'b0; addr_i = 32'h104;
        @(negedge clk);
        req_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_valid", {31'd0, dmem_valid_o}, 32'd0);
        chk("rst_mid_ready", {31'd0, req_ready_o}, 32'd1);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("rst_mid_no_done", {31'd0, done_o}, 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
